// File: rtl/iiravg_mc.sv
// Multi-channel time-multiplexed first-order recursive averager: avg[ch] += (x - avg[ch]) >>> lgalpha.
// Define IIRAVG_ROUND_EN to round the shifted correction half-up instead of flooring it.
module iiravg_mc #(
  parameter int IW    = 16,
  parameter int OW    = 16,
  parameter int GUARD = 8,
  parameter int NCH   = 4,
  parameter int LAW   = 4
) (
  input  logic                     i_clk,
  input  logic                     i_areset_n,
  input  logic                     i_clear,
  input  logic [LAW-1:0]           i_lgalpha,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [$clog2(NCH)-1:0]   i_chan,
  input  logic [IW-1:0]            i_val,
  output logic                     o_valid,
  output logic [$clog2(NCH)-1:0]   o_chan,
  output logic [OW-1:0]            o_val
);

  localparam int LGNCH = $clog2(NCH);
  localparam int AW    = OW + GUARD;
  localparam int XSH   = AW - IW;

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  state_e            state_q, state_d;
  logic [LGNCH-1:0]  cnt_q, cnt_d;
  logic              clr_we;

  // ---------------------------------------------------------------------------
  // Control FSM: CLEAR sweeps zeros through every channel slot, RUN accepts data
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    if (i_clear) begin
      state_d = ST_CLEAR;
      cnt_d   = '0;
    end else if (state_q == ST_CLEAR) begin
      if (cnt_q == LGNCH'(NCH - 1)) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + LGNCH'(1);
      end
    end
  end

  always_comb begin
    o_ready = 1'b0;
    clr_we  = 1'b0;
    case (state_q)
      ST_CLEAR: clr_we  = 1'b1;
      ST_RUN:   o_ready = 1'b1;
      default:  ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage 1 capture: a clear pulse outranks a same-cycle accepted sample
  // ---------------------------------------------------------------------------
  logic              accept;
  logic              s1_valid_q;
  logic [LGNCH-1:0]  s1_chan_q;
  logic [IW-1:0]     s1_val_q;
  logic [LAW-1:0]    s1_lga_q;

  assign accept = i_valid && o_ready && !i_clear;

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      s1_valid_q <= 1'b0;
      s1_chan_q  <= '0;
      s1_val_q   <= '0;
      s1_lga_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_chan_q <= i_chan;
        s1_val_q  <= i_val;
        s1_lga_q  <= i_lgalpha;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Channel state RAM: one write port shared by the clear sweep and write-back
  // ---------------------------------------------------------------------------
  logic [AW-1:0]     mem [NCH];
  logic [AW-1:0]     rd_data_q;
  logic              chan_ok;
  logic              wb_en;
  logic              ram_we;
  logic [LGNCH-1:0]  ram_waddr;
  logic [AW-1:0]     ram_wdata;
  logic signed [AW-1:0] avg_new;

  assign chan_ok   = {1'b0, s1_chan_q} < (LGNCH + 1)'(NCH);
  assign wb_en     = s1_valid_q && chan_ok && !i_clear;
  assign ram_we    = clr_we || wb_en;
  assign ram_waddr = clr_we ? cnt_q : s1_chan_q;
  assign ram_wdata = clr_we ? '0 : avg_new;

  // NOTE: the state RAM has no reset; the CLEAR sweep zeroes it, which keeps it mappable to block RAM.
  always_ff @(posedge i_clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    rd_data_q <= mem[i_chan];
  end

  // ---------------------------------------------------------------------------
  // Stage 1 compute, with the previous write-back forwarded over the RAM read
  // ---------------------------------------------------------------------------
  logic                 out_valid_q;
  logic [LGNCH-1:0]     out_chan_q;
  logic [OW-1:0]        out_val_q;
  logic [AW-1:0]        wb_avg_q;
  logic signed [AW-1:0] avg_cur;
  logic signed [AW-1:0] x_s;
  logic signed [AW:0]   diff;
  logic signed [AW+1:0] adj_w;
`ifdef IIRAVG_ROUND_EN
  logic signed [AW+1:0] bias;
`endif

  always_comb begin
    avg_cur = (out_valid_q && (out_chan_q == s1_chan_q)) ? wb_avg_q : rd_data_q;
    x_s     = AW'($signed(s1_val_q)) <<< XSH;
    diff    = (AW + 1)'(x_s) - (AW + 1)'(avg_cur);
`ifdef IIRAVG_ROUND_EN
    bias    = (s1_lga_q == '0) ? '0 : ((AW + 2)'(1) << (s1_lga_q - LAW'(1)));
    adj_w   = ((AW + 2)'(diff) + bias) >>> s1_lga_q;
`else
    adj_w   = (AW + 2)'(diff) >>> s1_lga_q;
`endif
    // Convex combination of avg and x, so dropping the top bits loses nothing.
    avg_new = AW'((AW + 2)'(avg_cur) + adj_w);
  end

  // ---------------------------------------------------------------------------
  // Stage 2: registered result strobe, doubling as the forwarding source
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_val_q   <= '0;
      wb_avg_q    <= '0;
    end else begin
      out_valid_q <= wb_en;
      if (wb_en) begin
        out_chan_q <= s1_chan_q;
        out_val_q  <= avg_new[AW-1:GUARD];
        wb_avg_q   <= avg_new;
      end
    end
  end

  assign o_valid = out_valid_q;
  assign o_chan  = out_chan_q;
  assign o_val   = out_val_q;

endmodule

// File: tb/tb_iiravg_mc.sv
// Self-checking bench for iiravg_mc: directed scenarios plus random traffic against a per-channel arithmetic model.
module tb_iiravg_mc;

  localparam int IW = 16, OW = 16, GUARD = 8, NCH = 4, LAW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default-configured DUT
  logic             clear, valid, ready, o_valid;
  logic [LAW-1:0]   lga;
  logic [1:0]       chan, o_chan;
  logic [15:0]      val, o_val;

  iiravg_mc #(.IW(IW), .OW(OW), .GUARD(GUARD), .NCH(NCH), .LAW(LAW)) u_dut (
    .i_clk(clk), .i_areset_n(rst_n), .i_clear(clear), .i_lgalpha(lga),
    .i_valid(valid), .o_ready(ready), .i_chan(chan), .i_val(val),
    .o_valid(o_valid), .o_chan(o_chan), .o_val(o_val)
  );

  // Second DUT: no guard bits, three channels (exercises rounding and out-of-range channel)
  logic             b_clear, b_valid, b_ready, b_o_valid;
  logic [LAW-1:0]   b_lga;
  logic [1:0]       b_chan, b_o_chan;
  logic [15:0]      b_val, b_o_val;
  bit               b_done = 1'b0;

  iiravg_mc #(.IW(16), .OW(16), .GUARD(0), .NCH(3), .LAW(LAW)) u_dut_b (
    .i_clk(clk), .i_areset_n(rst_n), .i_clear(b_clear), .i_lgalpha(b_lga),
    .i_valid(b_valid), .o_ready(b_ready), .i_chan(b_chan), .i_val(b_val),
    .o_valid(b_o_valid), .o_chan(b_o_chan), .o_val(b_o_val)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: exact per-channel averages and an in-order queue of expected results
  typedef struct {
    int          due;
    int          ch;
    logic [15:0] val;
  } exp_t;

  exp_t   exp_q[$];
  longint avg_m [NCH];
  int     cyc;
  int     clr_left;

  // One update step: x scaled by 2**guard, correction = floor(diff / 2**lg) (optionally +half first)
  function automatic longint ref_step(input longint avg, input logic [15:0] x_in, input int lg,
                                      input int guard);
    longint x, diff;
    x    = longint'($signed(x_in)) * (longint'(1) << guard);
    diff = x - avg;
`ifdef IIRAVG_ROUND_EN
    if (lg > 0) diff = diff + (longint'(1) << (lg - 1));
`endif
    return avg + (diff >>> lg);
  endfunction

  // Drive one cycle of stimulus, check outputs mid-cycle, advance the model past the edge
  task automatic cycle(input bit v, input int ch, input logic [15:0] d, input int lg, input bit clr);
    valid = v;
    chan  = ch[1:0];
    val   = d;
    lga   = lg[LAW-1:0];
    clear = clr;
    @(negedge clk);
    check("o_ready", ready, clr_left == 0);
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      check("o_valid", o_valid, 1);
      check("o_chan", o_chan, exp_q[0].ch);
      check("o_val", o_val, exp_q[0].val);
      void'(exp_q.pop_front());
    end else begin
      check("o_valid_idle", o_valid, 0);
    end
    if (v && clr_left == 0 && !clr) begin
      avg_m[ch] = ref_step(avg_m[ch], d, lg, GUARD);
      exp_q.push_back('{cyc + 2, ch, 16'(avg_m[ch] >>> GUARD)});
    end
    if (clr) begin
      exp_q.delete();
      foreach (avg_m[i]) avg_m[i] = 0;
      clr_left = NCH;
    end else if (clr_left > 0) begin
      clr_left--;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 0, 16'h0000, 0, 1'b0);
  endtask

  initial begin
    clear = 1'b0; valid = 1'b0; chan = '0; val = '0; lga = '0;
    foreach (avg_m[i]) avg_m[i] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_o_valid", o_valid, 0);
    check("rst_o_ready", ready, 0);
    check("rst_o_chan", o_chan, 0);
    check("rst_o_val", o_val, 0);
    check("rst_b_ready", b_ready, 0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    cyc      = 0;
    clr_left = NCH;

    idle(5);
    // Single channel, spaced samples
    cycle(1'b1, 0, 16'h1000, 4, 1'b0); idle(3);
    cycle(1'b1, 0, 16'h1000, 4, 1'b0); idle(3);
    // Back-to-back on one channel (forwarding)
    cycle(1'b1, 1, 16'h1000, 4, 1'b0);
    cycle(1'b1, 1, 16'h1000, 4, 1'b0); idle(3);
    // Fresh state, then an interleaved channel and the extreme shift/value cases
    cycle(1'b0, 0, 16'h0000, 0, 1'b1); idle(5);
    cycle(1'b1, 1, 16'h1000, 4, 1'b0);
    cycle(1'b1, 2, 16'h1000, 4, 1'b0);
    cycle(1'b1, 1, 16'h1000, 4, 1'b0);
    cycle(1'b1, 3, 16'h8000, 0, 1'b0);
    cycle(1'b1, 0, 16'hFFFF, 4, 1'b0); idle(3);
    // Clear with two samples in flight and a third presented alongside the pulse
    cycle(1'b1, 0, 16'h1234, 3, 1'b0);
    cycle(1'b1, 1, 16'h4321, 2, 1'b0);
    cycle(1'b1, 2, 16'h5555, 1, 1'b1);
    idle(5);
    cycle(1'b1, 0, 16'h1000, 4, 1'b0); idle(3);

    // Random traffic with occasional clears and extreme sample values
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] d;
      case ($urandom_range(0, 7))
        0:       d = 16'h8000;
        1:       d = 16'h7FFF;
        default: d = 16'($urandom);
      endcase
      cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, NCH - 1)), d,
            int'($urandom_range(0, 15)), $urandom_range(0, 99) == 0);
    end
    idle(4);
    check("drain_empty", exp_q.size(), 0);
    check("dut_b_done", b_done, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Directed sequence for the GUARD=0, NCH=3 instance
`ifdef IIRAVG_ROUND_EN
  localparam logic [15:0] B_E1 = 16'd2, B_E2 = 16'd3;
`else
  localparam logic [15:0] B_E1 = 16'd1, B_E2 = 16'd2;
`endif

  initial begin
    b_clear = 1'b0; b_valid = 1'b0; b_chan = '0; b_val = '0; b_lga = '0;
    @(posedge rst_n);
    for (int k = 0; k < 9; k++) begin
      b_valid = (k == 3) || (k == 4) || (k == 5);
      b_chan  = (k == 4) ? 2'd3 : 2'd0;
      b_val   = (k == 4) ? 16'd100 : 16'd3;
      b_lga   = (k == 4) ? LAW'(0) : LAW'(1);
      @(negedge clk);
      check("b_ready", b_ready, k >= 3);
      check("b_o_valid", b_o_valid, (k == 5) || (k == 7));
      if (k == 5) begin
        check("b_o_chan1", b_o_chan, 0);
        check("b_o_val1", b_o_val, B_E1);
      end
      if (k == 7) begin
        check("b_o_chan2", b_o_chan, 0);
        check("b_o_val2", b_o_val, B_E2);
      end
      @(posedge clk);
      #1;
    end
    b_valid = 1'b0;
    b_done  = 1'b1;
  end

endmodule
